// File: rtl/srambank_param.sv
// Parametrised multi-bank synchronous SRAM model with masked writes, 1/2-cycle read
// latency, read/write collision flag and a post-reset zero-fill sequencer.
module srambank_param #(
    parameter int WIDTH     = 40,
    parameter int DEPTH     = 128,
    parameter int NBANKS    = 4,
    parameter int MASK_GRAN = 8,
    parameter int READ_LAT  = 1,
    localparam int AW       = $clog2(NBANKS * DEPTH),
    localparam int MW       = WIDTH / MASK_GRAN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ADDRESS,
    input  logic [WIDTH-1:0] wd,
    input  logic [MW-1:0]    wmask,
    input  logic             banksel,
    input  logic             read,
    input  logic             write,
    output logic [WIDTH-1:0] dataout,
    output logic             rvalid,
    output logic             busy,
    output logic             collision
);

    localparam int NWORDS = NBANKS * DEPTH;
    localparam logic [AW:0] LAST_ADDR = (AW + 1)'(NWORDS - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    state_e           state_q;
    logic [AW:0]      init_cnt_q;
    logic             busy_q;

    logic [WIDTH-1:0] mem_q [NWORDS];

    logic             accept;
    logic             wr_en;
    logic             rd_en;
    logic             coll_en;
    logic             init_we;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] merged_d;

    logic             rd_valid_pre;
    logic [WIDTH-1:0] rd_data_pre;

    logic [WIDTH-1:0] dataout_q;
    logic             rvalid_q;
    logic             collision_q;

    // A read that coincides with a write is dropped; only the write lands.
    assign accept  = banksel & ~busy_q;
    assign wr_en   = accept & write;
    assign rd_en   = accept & read & ~write;
    assign coll_en = accept & read & write;
    assign init_we = (state_q == ST_INIT);
    assign rd_word = mem_q[ADDRESS];

    always_comb begin
        merged_d = rd_word;
        for (int i = 0; i < MW; i++) begin
            if (wmask[i]) begin
                merged_d[i*MASK_GRAN +: MASK_GRAN] = wd[i*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    // Init sequencer: zero one word per cycle, leave INIT on the last address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_INIT;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Array contents are not reset; the init sequencer owns the write port while busy.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_cnt_q[AW-1:0]] <= '0;
        end else if (wr_en) begin
            mem_q[ADDRESS] <= merged_d;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic             stage_valid_q;
            logic [WIDTH-1:0] stage_data_q;

            // Stage captures the word at the read edge, so a following write cannot disturb it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stage_valid_q <= 1'b0;
                    stage_data_q  <= '0;
                end else begin
                    stage_valid_q <= rd_en;
                    if (rd_en) begin
                        stage_data_q <= rd_word;
                    end
                end
            end

            assign rd_valid_pre = stage_valid_q;
            assign rd_data_pre  = stage_data_q;
        end else begin : g_lat1
            assign rd_valid_pre = rd_en;
            assign rd_data_pre  = rd_word;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataout_q   <= '0;
            rvalid_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            rvalid_q    <= rd_valid_pre;
            collision_q <= coll_en;
            if (rd_valid_pre) begin
                dataout_q <= rd_data_pre;
            end
        end
    end

    assign dataout   = dataout_q;
    assign rvalid    = rvalid_q;
    assign busy      = busy_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_srambank_param.sv
// Directed bench for srambank_param: one READ_LAT=1 and one READ_LAT=2 instance share inputs.
module tb_srambank_param;

  localparam int W  = 40;
  localparam int AW = 9;
  localparam int MW = 5;

  logic          clk;
  logic          reset;
  logic [AW-1:0] addr;
  logic [W-1:0]  wd;
  logic [MW-1:0] wmask;
  logic          banksel;
  logic          rd;
  logic          wr;

  logic [W-1:0]  d1, d2;
  logic          rv1, rv2, busy1, busy2, col1, col2;

  int total;
  int bad;

  srambank_param #(.WIDTH(40), .DEPTH(128), .NBANKS(4), .MASK_GRAN(8), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .ADDRESS(addr), .wd(wd), .wmask(wmask), .banksel(banksel),
    .read(rd), .write(wr), .dataout(d1), .rvalid(rv1), .busy(busy1), .collision(col1)
  );

  srambank_param #(.WIDTH(40), .DEPTH(128), .NBANKS(4), .MASK_GRAN(8), .READ_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .ADDRESS(addr), .wd(wd), .wmask(wmask), .banksel(banksel),
    .read(rd), .write(wr), .dataout(d2), .rvalid(rv2), .busy(busy2), .collision(col2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic idle_inputs;
    addr = '0; wd = '0; wmask = '0; banksel = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d,
                          input logic [MW-1:0] m, input logic bs);
    addr = a; wd = d; wmask = m; banksel = bs; wr = 1'b1; rd = 1'b0;
    tick;
    idle_inputs;
  endtask

  // p1/p2: a single, correctly timed rvalid pulse on each instance.
  task automatic do_read(input logic [AW-1:0] a, output logic [W-1:0] q1,
                         output logic [W-1:0] q2, output logic p1, output logic p2);
    logic r1a, r1b, r2a, r2b, r2c;
    addr = a; banksel = 1'b1; rd = 1'b1; wr = 1'b0;
    tick;
    r1a = rv1; q1 = d1; r2a = rv2;
    idle_inputs;
    tick;
    r1b = rv1; r2b = rv2; q2 = d2;
    tick;
    r2c = rv2;
    p1 = r1a & ~r1b;
    p2 = ~r2a & r2b & ~r2c;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs;
    tick;
    tick;
    total++; if (d1 !== '0) begin bad++; $display("FAIL reset_dataout1: got %0h want 0", d1); end
    total++; if (d2 !== '0) begin bad++; $display("FAIL reset_dataout2: got %0h want 0", d2); end
    total++; if (rv1 !== 1'b0 || rv2 !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b%b want 00", rv1, rv2); end
    total++; if (col1 !== 1'b0 || col2 !== 1'b0) begin bad++; $display("FAIL reset_collision: got %b%b want 00", col1, col2); end
    total++; if (busy1 !== 1'b1 || busy2 !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b%b want 11", busy1, busy2); end
    reset = 1'b0;
  endtask

  task automatic test_init;
    int n;
    logic seen_rv;
    logic [W-1:0] q1, q2;
    logic p1, p2;
    logic [AW-1:0] addrs [4];
    addrs = '{9'd0, 9'd255, 9'd511, 9'd3};
    n = 0;
    seen_rv = 1'b0;
    while (busy1 === 1'b1 && n < 2000) begin
      idle_inputs;
      if (n == 100) begin
        addr = 9'd3; wd = '1; wmask = '1; banksel = 1'b1; wr = 1'b1;
      end else if (n == 101) begin
        addr = 9'd3; banksel = 1'b1; rd = 1'b1;
      end
      tick;
      if (rv1 === 1'b1 || rv2 === 1'b1) seen_rv = 1'b1;
      n++;
    end
    idle_inputs;
    total++; if (n != 512) begin bad++; $display("FAIL init_busy_cycles: got %0d want 512", n); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL init_busy2_done: got %b want 0", busy2); end
    total++; if (seen_rv !== 1'b0) begin bad++; $display("FAIL init_no_rvalid: got %b want 0", seen_rv); end
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i], q1, q2, p1, p2);
      total++; if (q1 !== '0) begin bad++; $display("FAIL init_read1 @%0d: got %0h want 0", addrs[i], q1); end
      total++; if (q2 !== '0) begin bad++; $display("FAIL init_read2 @%0d: got %0h want 0", addrs[i], q2); end
      total++; if (p1 !== 1'b1 || p2 !== 1'b1) begin bad++; $display("FAIL init_rvalid_pulse @%0d: got %b%b want 11", addrs[i], p1, p2); end
    end
  endtask

  task automatic test_masked_write;
    logic [W-1:0] q1, q2;
    logic p1, p2;
    do_write(9'd5, 40'hFF_FFFF_FFFF, 5'b11111, 1'b1);
    do_write(9'd5, 40'h00_0000_0000, 5'b00101, 1'b1);
    do_read(9'd5, q1, q2, p1, p2);
    total++; if (q1 !== 40'hFF_FF00_FF00) begin bad++; $display("FAIL mask_read1: got %0h want ffff00ff00", q1); end
    total++; if (q2 !== 40'hFF_FF00_FF00) begin bad++; $display("FAIL mask_read2: got %0h want ffff00ff00", q2); end
    do_write(9'd5, 40'h00_0000_0000, 5'b00000, 1'b1);
    do_read(9'd5, q1, q2, p1, p2);
    total++; if (q1 !== 40'hFF_FF00_FF00 || q2 !== 40'hFF_FF00_FF00) begin bad++; $display("FAIL mask_noop: got %0h/%0h want ffff00ff00", q1, q2); end
    do_write(9'd300, 40'h12_3456_789A, 5'b11111, 1'b1);
    do_read(9'd300, q1, q2, p1, p2);
    total++; if (q1 !== 40'h12_3456_789A || q2 !== 40'h12_3456_789A) begin bad++; $display("FAIL write_then_read: got %0h/%0h want 123456789a", q1, q2); end
    total++; if (p1 !== 1'b1 || p2 !== 1'b1) begin bad++; $display("FAIL write_then_read_pulse: got %b%b want 11", p1, p2); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q1, q2;
    logic p1, p2;
    do_write(9'd1, 40'hA, 5'b11111, 1'b1);
    do_write(9'd2, 40'hB, 5'b11111, 1'b1);
    do_write(9'd3, 40'hC, 5'b11111, 1'b1);
    addr = 9'd1; banksel = 1'b1; rd = 1'b1;
    tick;
    total++; if (rv2 !== 1'b0) begin bad++; $display("FAIL b2b_lat2_early: got %b want 0", rv2); end
    total++; if (rv1 !== 1'b1 || d1 !== 40'hA) begin bad++; $display("FAIL b2b_lat1_a: got %b/%0h want 1/a", rv1, d1); end
    addr = 9'd2;
    tick;
    total++; if (rv2 !== 1'b1 || d2 !== 40'hA) begin bad++; $display("FAIL b2b_lat2_a: got %b/%0h want 1/a", rv2, d2); end
    total++; if (rv1 !== 1'b1 || d1 !== 40'hB) begin bad++; $display("FAIL b2b_lat1_b: got %b/%0h want 1/b", rv1, d1); end
    addr = 9'd3;
    tick;
    total++; if (rv2 !== 1'b1 || d2 !== 40'hB) begin bad++; $display("FAIL b2b_lat2_b: got %b/%0h want 1/b", rv2, d2); end
    total++; if (rv1 !== 1'b1 || d1 !== 40'hC) begin bad++; $display("FAIL b2b_lat1_c: got %b/%0h want 1/c", rv1, d1); end
    idle_inputs;
    tick;
    total++; if (rv2 !== 1'b1 || d2 !== 40'hC) begin bad++; $display("FAIL b2b_lat2_c: got %b/%0h want 1/c", rv2, d2); end
    total++; if (rv1 !== 1'b0 || d1 !== 40'hC) begin bad++; $display("FAIL b2b_lat1_hold: got %b/%0h want 0/c", rv1, d1); end
    tick;
    total++; if (rv2 !== 1'b0 || d2 !== 40'hC) begin bad++; $display("FAIL b2b_lat2_hold: got %b/%0h want 0/c", rv2, d2); end
    // write right after a READ_LAT=2 read must not change that read's data
    addr = 9'd1; banksel = 1'b1; rd = 1'b1;
    tick;
    rd = 1'b0; wr = 1'b1; wd = 40'hD; wmask = '1;
    tick;
    total++; if (rv2 !== 1'b1 || d2 !== 40'hA) begin bad++; $display("FAIL rd_then_wr_lat2: got %b/%0h want 1/a", rv2, d2); end
    idle_inputs;
    tick;
    do_read(9'd1, q1, q2, p1, p2);
    total++; if (q1 !== 40'hD || q2 !== 40'hD) begin bad++; $display("FAIL rd_then_wr_new: got %0h/%0h want d", q1, q2); end
  endtask

  task automatic test_collision;
    logic [W-1:0] q1, q2;
    logic p1, p2;
    addr = 9'd9; wd = 40'h123; wmask = '1; banksel = 1'b1; rd = 1'b1; wr = 1'b1;
    tick;
    total++; if (col1 !== 1'b1 || col2 !== 1'b1) begin bad++; $display("FAIL coll_pulse: got %b%b want 11", col1, col2); end
    total++; if (rv1 !== 1'b0 || d1 !== 40'hD) begin bad++; $display("FAIL coll_lat1_out: got %b/%0h want 0/d", rv1, d1); end
    idle_inputs;
    tick;
    total++; if (col1 !== 1'b0 || col2 !== 1'b0) begin bad++; $display("FAIL coll_drop: got %b%b want 00", col1, col2); end
    total++; if (rv2 !== 1'b0 || d2 !== 40'hD) begin bad++; $display("FAIL coll_lat2_out: got %b/%0h want 0/d", rv2, d2); end
    do_read(9'd9, q1, q2, p1, p2);
    total++; if (q1 !== 40'h123 || q2 !== 40'h123) begin bad++; $display("FAIL coll_write_landed: got %0h/%0h want 123", q1, q2); end
  endtask

  task automatic test_ignored_idle;
    logic [W-1:0] q1, q2;
    logic p1, p2;
    do_write(9'd40, '1, '1, 1'b0);
    do_read(9'd40, q1, q2, p1, p2);
    total++; if (q1 !== '0 || q2 !== '0) begin bad++; $display("FAIL nosel_write: got %0h/%0h want 0", q1, q2); end
    addr = 9'd9; rd = 1'b1; banksel = 1'b0;
    tick;
    idle_inputs;
    tick;
    total++; if (rv1 !== 1'b0 || rv2 !== 1'b0) begin bad++; $display("FAIL nosel_read: got %b%b want 00", rv1, rv2); end
  endtask

  task automatic test_reset_mid_read_and_init;
    int n;
    logic [W-1:0] q1, q2;
    logic p1, p2;
    addr = 9'd5; banksel = 1'b1; rd = 1'b1;
    tick;
    idle_inputs;
    total++; if (d1 !== 40'hFF_FF00_FF00) begin bad++; $display("FAIL midread_pre: got %0h want ffff00ff00", d1); end
    reset = 1'b1;
    #1;
    total++; if (d1 !== '0 || d2 !== '0) begin bad++; $display("FAIL midread_async_data: got %0h/%0h want 0", d1, d2); end
    total++; if (busy1 !== 1'b1 || busy2 !== 1'b1) begin bad++; $display("FAIL midread_async_busy: got %b%b want 11", busy1, busy2); end
    tick;
    tick;
    reset = 1'b0;
    tick;
    tick;
    total++; if (rv2 !== 1'b0 || d2 !== '0) begin bad++; $display("FAIL midread_cancel: got %b/%0h want 0/0", rv2, d2); end
    for (int i = 0; i < 98; i++) tick;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL midinit_busy: got %b want 1", busy1); end
    reset = 1'b1;
    #1;
    total++; if (busy1 !== 1'b1 || rv1 !== 1'b0 || col1 !== 1'b0 || d1 !== '0) begin bad++; $display("FAIL midinit_outputs: got %b%b%b/%0h want 100/0", busy1, rv1, col1, d1); end
    tick;
    tick;
    reset = 1'b0;
    n = 0;
    while (busy1 === 1'b1 && n < 2000) begin
      tick;
      n++;
    end
    total++; if (n != 512) begin bad++; $display("FAIL midinit_busy_cycles: got %0d want 512", n); end
    do_read(9'd5, q1, q2, p1, p2);
    total++; if (q1 !== '0 || q2 !== '0) begin bad++; $display("FAIL midinit_rezeroed5: got %0h/%0h want 0", q1, q2); end
    do_read(9'd9, q1, q2, p1, p2);
    total++; if (q1 !== '0 || q2 !== '0) begin bad++; $display("FAIL midinit_rezeroed9: got %0h/%0h want 0", q1, q2); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    idle_inputs;
    reset = 1'b1;
    test_reset;
    test_init;
    test_masked_write;
    test_back_to_back;
    test_collision;
    test_ignored_idle;
    test_reset_mid_read_and_init;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
